pcm_frame_sync_ctrl: RTL and testbench
======================================

Name: pcm_frame_sync_ctrl

Overview:
Frame-synchronisation controller for the CM PCM NRZ downlink path. It consumes the recovered bit stream and its one-cycle sample strobe from the bit-timing front end. It runs a SEARCH/VERIFY/LOCK/FLYWHEEL acquisition state machine against the frame sync pattern. While in sync it emits framed bytes tagged with word index and frame-start markers to the downstream byte sink.

Parameters:
FRAME_WORDS, 128, 8-bit words per frame; frame length FRAME_BITS = 8*FRAME_WORDS, must be >= SYNC_LEN
SYNC_LEN, 26, sync pattern length in bits
SYNC_PATTERN, 26'b00000101_01111001_10110111_11, expected sync bits, MSB received first
MAX_ERRS, 0, bit mismatches tolerated in a sync match (Hamming distance)
VERIFY_COUNT, 2, consecutive on-time matches (including the acquiring match) needed to declare lock, >= 1
FLYWHEEL_COUNT, 3, consecutive misses tolerated before dropping lock, >= 1

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
bit_in  input  1  recovered NRZ bit, valid when bit_sample=1
bit_sample  input  1  one-cycle strobe, one per received bit
resync  input  1  pulse: force return to SEARCH
word_data  output  8  assembled byte, MSB = earliest bit
word_valid  output  1  one-cycle pulse, word_data/word_index valid
word_index  output  $clog2(FRAME_WORDS)  index of word within frame
frame_start  output  1  asserted with word_valid when word_index==0
lock  output  1  state is LOCK or FLYWHEEL
sync_state  output  2  0=SEARCH 1=VERIFY 2=LOCK 3=FLYWHEEL
frame_count  output  16  frames completed while locked, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0, state SEARCH, shift register, bit_pos, hit/miss counters cleared.
- On each bit_sample: shift register sr <= {sr[SYNC_LEN-2:0], bit_in}. Match is evaluated on the post-shift value, {sr[SYNC_LEN-2:0], bit_in}, in the same cycle. match = popcount(value XOR SYNC_PATTERN) <= MAX_ERRS.
- bit_pos counts 1..FRAME_BITS and is reset to 0 at every sync point. The check instant is the bit_sample where bit_pos reaches FRAME_BITS.
- SEARCH: match evaluated on every bit_sample. On match -> VERIFY with bit_pos=0 and hits=1, or directly to LOCK if VERIFY_COUNT==1.
- VERIFY: on a match at the check instant, hits++; when hits==VERIFY_COUNT -> LOCK. A miss at the check instant -> SEARCH. Matches off the check instant are ignored.
- LOCK: a match at the check instant stays in LOCK with misses=0. A miss -> FLYWHEEL with misses=1, or SEARCH if FLYWHEEL_COUNT==1.
- FLYWHEEL: a match -> LOCK with misses=0. A miss increments misses; when misses==FLYWHEEL_COUNT -> SEARCH. bit_pos keeps its frame alignment (wraps to 0) on a miss.
- Word output only in LOCK and FLYWHEEL:
  - Each bit_sample with bit_pos[2:0] completing a multiple of 8 produces word_valid one cycle after that strobe (registered).
  - word_index = bit_pos/8 - 1.
  - The last word of a frame contains the trailing sync bits.
- The word produced at the check instant that confirms or keeps lock is word FRAME_WORDS-1. frame_count increments at that same instant.
- The first emitted word after entering LOCK is index 0 of the following frame.
- Entering SEARCH (miss limit reached, or resync) suppresses any further word_valid. A word already registered in the cycle of transition still completes.
- resync has priority over a coincident bit_sample: the bit is shifted but no match or state update is made. frame_count is held, not cleared.
- Reset asserted mid-frame: all state is cleared on the next clk edge and no partial word is emitted.

Decomposition:
- Package pcm_sync_pkg: state encoding constants SYNC_SEARCH/VERIFY/LOCK/FLYWHEEL, default SYNC_PATTERN, SYNC_LEN.
- Sub-module pcm_sync_match: combinational Hamming-distance compare of a SYNC_LEN vector against the pattern, with MAX_ERRS threshold, output match.

Test Plan:
- Three clean frames (pattern at bits 999..1024 of each 1024-bit frame): SEARCH->VERIFY on first pattern, LOCK at second check. word_valid follows for words 0..127 of the third frame, frame_start with index 0, frame_count=1 after the third check.
- Locked, corrupt one sync bit in two consecutive frames, then clean: state LOCK->FLYWHEEL->FLYWHEEL->LOCK; bytes flow uninterrupted with 128 words per frame.
- Locked, corrupt sync in three consecutive frames: SEARCH after third check, lock=0, no word_valid thereafter until reacquired.
- False pattern inserted mid-frame while in SEARCH, absent at +1024 bits: VERIFY then back to SEARCH, zero word_valid pulses.
- MAX_ERRS=1 build: sync with 1 bit error keeps LOCK; with 2 errors enters FLYWHEEL.
- resync pulse coincident with a bit_sample while locked: state=SEARCH next cycle, frame_count unchanged. Reset mid-frame: all outputs 0 next cycle.

Source files
------------

// File: rtl/pcm_sync_pkg.sv
// Shared definitions for the PCM frame-sync controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//   SYNC_LEN_DEFAULT / SYNC_PATTERN_DEFAULT : default frame sync word, MSB received first
//   sync_state_t                            : acquisition state encoding as seen on sync_state
package pcm_sync_pkg;

  localparam int SYNC_LEN_DEFAULT = 26;
  localparam logic [SYNC_LEN_DEFAULT-1:0] SYNC_PATTERN_DEFAULT =
    26'b00000101_01111001_10110111_11;

  typedef enum logic [1:0] {
    SYNC_SEARCH   = 2'd0,
    SYNC_VERIFY   = 2'd1,
    SYNC_LOCK     = 2'd2,
    SYNC_FLYWHEEL = 2'd3
  } sync_state_t;

endpackage

// File: rtl/pcm_sync_match.sv
// Hamming-distance comparator of a received window against the sync pattern.
// Latency: combinational.
// Backpressure: none.
//   data  : SYNC_LEN-bit window, MSB = earliest received bit
//   match : 1 when the number of differing bits is <= MAX_ERRS
module pcm_sync_match #(
  parameter int                  SYNC_LEN     = 26,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = '0,
  parameter int                  MAX_ERRS     = 0
) (
  input  logic [SYNC_LEN-1:0] data,
  output logic                match
);

  localparam int ERR_W = $clog2(SYNC_LEN + 1);

  logic [SYNC_LEN-1:0] diff;
  logic [ERR_W-1:0]    errs;

  always_comb begin
    diff = data ^ SYNC_PATTERN;
    errs = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      errs = errs + ERR_W'(diff[i]);
    end
    match = (int'(errs) <= MAX_ERRS);
  end

endmodule

// File: rtl/pcm_frame_sync_ctrl.sv
// Frame-sync acquisition (SEARCH/VERIFY/LOCK/FLYWHEEL) and byte framing for the PCM NRZ downlink.
// Latency: word_valid/word_data/word_index/frame_start registered, one clk after the completing bit_sample.
// Backpressure: none; the downstream byte sink must accept every word_valid pulse.
//   clk, reset_n (sync, active-low) | bit_in + bit_sample: bit stream in | resync: force SEARCH
//   word_data/word_valid/word_index/frame_start: framed bytes out | lock, sync_state, frame_count: status
module pcm_frame_sync_ctrl
  import pcm_sync_pkg::*;
#(
  parameter int                  FRAME_WORDS    = 128,
  parameter int                  SYNC_LEN       = SYNC_LEN_DEFAULT,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN   = SYNC_PATTERN_DEFAULT,
  parameter int                  MAX_ERRS       = 0,
  parameter int                  VERIFY_COUNT   = 2,
  parameter int                  FLYWHEEL_COUNT = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           bit_in,
  input  logic                           bit_sample,
  input  logic                           resync,
  output logic [7:0]                     word_data,
  output logic                           word_valid,
  output logic [$clog2(FRAME_WORDS)-1:0] word_index,
  output logic                           frame_start,
  output logic                           lock,
  output logic [1:0]                     sync_state,
  output logic [15:0]                    frame_count
);

  localparam int FRAME_BITS = 8 * FRAME_WORDS;
  localparam int POS_W      = $clog2(FRAME_BITS + 1);
  localparam int IDX_W      = $clog2(FRAME_WORDS);
  localparam int HIT_W      = $clog2(VERIFY_COUNT + 1);
  localparam int MISS_W     = $clog2(FLYWHEEL_COUNT + 1);

  sync_state_t         state_q, state_d;
  // The oldest bit of the window is only needed on the cycle it is shifted
  // out, so the register keeps SYNC_LEN-1 bits and the window is formed with bit_in.
  logic [SYNC_LEN-2:0] sr_q;
  logic [SYNC_LEN-1:0] sr_shift;
  logic [POS_W-1:0]    bit_pos_q, bit_pos_d, pos_inc;
  logic [HIT_W-1:0]    hits_q, hits_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic                match, check, locked_now, emit;
  logic [IDX_W-1:0]    idx_d;

  pcm_sync_match #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_PATTERN (SYNC_PATTERN),
    .MAX_ERRS     (MAX_ERRS)
  ) u_match (
    .data  (sr_shift),
    .match (match)
  );

  always_comb begin
    sr_shift   = {sr_q, bit_in};
    pos_inc    = bit_pos_q + 1'b1;
    check      = (pos_inc == POS_W'(FRAME_BITS));
    locked_now = (state_q == SYNC_LOCK) || (state_q == SYNC_FLYWHEEL);
    state_d    = state_q;
    bit_pos_d  = bit_pos_q;
    hits_d     = hits_q;
    misses_d   = misses_q;

    if (resync) begin
      state_d   = SYNC_SEARCH;
      bit_pos_d = '0;
      hits_d    = '0;
      misses_d  = '0;
    end else if (bit_sample) begin
      unique case (state_q)
        SYNC_SEARCH: begin
          if (match) begin
            state_d   = (VERIFY_COUNT == 1) ? SYNC_LOCK : SYNC_VERIFY;
            bit_pos_d = '0;
            hits_d    = HIT_W'(1);
            misses_d  = '0;
          end
        end
        SYNC_VERIFY: begin
          bit_pos_d = pos_inc;
          if (check) begin
            bit_pos_d = '0;
            if (!match) begin
              state_d = SYNC_SEARCH;
              hits_d  = '0;
            end else begin
              hits_d = hits_q + 1'b1;
              if (hits_d == HIT_W'(VERIFY_COUNT)) state_d = SYNC_LOCK;
            end
          end
        end
        SYNC_LOCK, SYNC_FLYWHEEL: begin
          bit_pos_d = pos_inc;
          if (check) begin
            // Frame alignment is kept on a miss: the count wraps like a hit.
            bit_pos_d = '0;
            if (match) begin
              state_d  = SYNC_LOCK;
              misses_d = '0;
            end else begin
              misses_d = misses_q + 1'b1;
              if (misses_d == MISS_W'(FLYWHEEL_COUNT)) begin
                state_d  = SYNC_SEARCH;
                misses_d = '0;
                hits_d   = '0;
              end else begin
                state_d = SYNC_FLYWHEEL;
              end
            end
          end
        end
      endcase
    end

    // A word is produced only while the controller stays in sync; the strobe
    // that drops lock (or a resync) emits nothing. FRAME_BITS is a multiple
    // of 8, so the check instant always coincides with the last word.
    emit  = bit_sample && !resync && locked_now && (pos_inc[2:0] == 3'd0)
            && (state_d != SYNC_SEARCH);
    idx_d = IDX_W'((pos_inc >> 3) - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= SYNC_SEARCH;
      sr_q        <= '0;
      bit_pos_q   <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_index  <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      bit_pos_q   <= bit_pos_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      if (bit_sample) sr_q <= sr_shift[SYNC_LEN-2:0];
      word_valid  <= emit;
      frame_start <= emit && (idx_d == '0);
      if (emit) begin
        word_data  <= sr_shift[7:0];
        word_index <= idx_d;
      end
      if (emit && check) frame_count <= frame_count + 1'b1;
    end
  end

  assign lock       = (state_q == SYNC_LOCK) || (state_q == SYNC_FLYWHEEL);
  assign sync_state = state_q;

endmodule

// File: tb/tb_pcm_frame_sync_ctrl.sv
// Directed bench for pcm_frame_sync_ctrl: acquisition, flywheel, loss, false sync, resync, reset, MAX_ERRS=1.
// Latency: checks word outputs one clk after the completing bit strobe.
// Backpressure: n/a.
module tb_pcm_frame_sync_ctrl;

  localparam logic [25:0] PAT = 26'b00000101_01111001_10110111_11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_sample = 1'b0;
  logic        resync = 1'b0;

  logic [7:0]  word_data;
  logic        word_valid;
  logic [6:0]  word_index;
  logic        frame_start;
  logic        lock;
  logic [1:0]  sync_state;
  logic [15:0] frame_count;

  logic [7:0]  e1_word_data;
  logic        e1_word_valid;
  logic [6:0]  e1_word_index;
  logic        e1_frame_start;
  logic        e1_lock;
  logic [1:0]  e1_sync_state;
  logic [15:0] e1_frame_count;

  int tests = 0;
  int fails = 0;

  logic [1:2048] st;
  logic [15:0]   wq[$];

  always #5 clk = ~clk;

  pcm_frame_sync_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_sample(bit_sample), .resync(resync),
    .word_data(word_data), .word_valid(word_valid), .word_index(word_index),
    .frame_start(frame_start), .lock(lock), .sync_state(sync_state), .frame_count(frame_count)
  );

  pcm_frame_sync_ctrl #(.MAX_ERRS(1)) u_dut_e1 (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_sample(bit_sample), .resync(resync),
    .word_data(e1_word_data), .word_valid(e1_word_valid), .word_index(e1_word_index),
    .frame_start(e1_frame_start), .lock(e1_lock), .sync_state(e1_sync_state),
    .frame_count(e1_frame_count)
  );

  always @(negedge clk) begin
    if (word_valid) wq.push_back({frame_start, word_index, word_data});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // Payload bytes always carry ones in bit positions 4 and 0, so the payload
  // never contains the pattern's 00000 prefix and cannot alias the sync word.
  function automatic logic [7:0] pay_byte(input int w, input int seed);
    logic [7:0] b;
    b = 8'((w * 3 + seed) & 255);
    return b | 8'h11;
  endfunction

  task automatic build_frame(input int seed, input logic [25:0] err_mask);
    for (int w = 0; w < 128; w++) st[8*w+1 +: 8] = pay_byte(w, seed);
    st[999 +: 26] = PAT ^ err_mask;
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_sample = 1'b1;
    @(posedge clk); #1;
    bit_sample = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_bit(st[i]);
      if (i % 16 == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bit_sample = 1'b0; resync = 1'b0; bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bit_sample = 1'b1; bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bit_sample = 1'b0;
    tests++;
    if ({word_valid, frame_start, word_data, word_index} !== 17'd0) begin
      fails++; $display("FAIL reset_word: got v=%b fs=%b d=%h i=%0d, want all 0", word_valid, frame_start, word_data, word_index);
    end
    tests++;
    if ({lock, sync_state, frame_count} !== 19'd0) begin
      fails++; $display("FAIL reset_status: got lock=%b st=%0d fc=%0d, want 0", lock, sync_state, frame_count);
    end
    do_reset();
  endtask

  task automatic test_acquire();
    logic [15:0] exp;
    build_frame(0, '0); send_range(1, 1024);
    tests++;
    if (sync_state !== 2'd1 || lock !== 1'b0) begin
      fails++; $display("FAIL acq_verify: got st=%0d lock=%b, want st=1 lock=0", sync_state, lock);
    end
    build_frame(1, '0); send_range(1, 1024);
    tests++;
    if (sync_state !== 2'd2 || lock !== 1'b1) begin
      fails++; $display("FAIL acq_lock: got st=%0d lock=%b, want st=2 lock=1", sync_state, lock);
    end
    tests++;
    if (wq.size() != 0 || frame_count !== 16'd0) begin
      fails++; $display("FAIL acq_no_words: got words=%0d fc=%0d, want 0 and 0", wq.size(), frame_count);
    end
    wq.delete();
    build_frame(2, '0); send_range(1, 1024);
    @(negedge clk);
    tests++;
    if (wq.size() != 128) begin
      fails++; $display("FAIL acq_word_count: got %0d, want 128", wq.size());
    end
    for (int w = 0; w < 128 && w < wq.size(); w++) begin
      exp = {(w == 0), 7'(w), st[8*w+1 +: 8]};
      tests++;
      if (wq[w] !== exp) begin
        fails++; $display("FAIL acq_word%0d: got {fs,idx,data}=%h, want %h", w, wq[w], exp);
      end
    end
    tests++;
    if (frame_count !== 16'd1) begin
      fails++; $display("FAIL acq_frame_count: got %0d, want 1", frame_count);
    end
  endtask

  task automatic test_flywheel();
    logic [15:0] exp;
    logic [1:0]  want [3] = '{2'd3, 2'd3, 2'd2};
    for (int f = 0; f < 3; f++) begin
      wq.delete();
      build_frame(3 + f, (f < 2) ? 26'h0000001 : 26'h0);
      send_range(1, 1024);
      @(negedge clk);
      tests++;
      if (sync_state !== want[f] || lock !== 1'b1) begin
        fails++; $display("FAIL fly_state%0d: got st=%0d lock=%b, want st=%0d lock=1", f, sync_state, lock, want[f]);
      end
      tests++;
      if (wq.size() != 128) begin
        fails++; $display("FAIL fly_count%0d: got %0d words, want 128", f, wq.size());
      end
    end
    for (int w = 0; w < 128 && w < wq.size(); w++) begin
      exp = {(w == 0), 7'(w), st[8*w+1 +: 8]};
      tests++;
      if (wq[w] !== exp) begin
        fails++; $display("FAIL fly_word%0d: got %h, want %h", w, wq[w], exp);
      end
    end
  endtask

  task automatic test_loss();
    logic [1:0] want [3] = '{2'd3, 2'd3, 2'd0};
    for (int f = 0; f < 3; f++) begin
      build_frame(6 + f, 26'h2000000);
      send_range(1, 1024);
      tests++;
      if (sync_state !== want[f]) begin
        fails++; $display("FAIL loss_state%0d: got %0d, want %0d", f, sync_state, want[f]);
      end
    end
    tests++;
    if (lock !== 1'b0) begin
      fails++; $display("FAIL loss_lock: got %b, want 0", lock);
    end
    wq.delete();
    build_frame(9, '0); send_range(1, 1024);
    @(negedge clk);
    tests++;
    if (wq.size() != 0 || sync_state !== 2'd1) begin
      fails++; $display("FAIL loss_quiet: got words=%0d st=%0d, want 0 words st=1", wq.size(), sync_state);
    end
  endtask

  task automatic test_resync();
    do_reset();
    for (int f = 0; f < 3; f++) begin build_frame(f, '0); send_range(1, 1024); end
    tests++;
    if (frame_count !== 16'd1) begin
      fails++; $display("FAIL rs_pre_fc: got %0d, want 1", frame_count);
    end
    wq.delete();
    build_frame(3, '0); send_range(1, 503);
    bit_in = st[504]; bit_sample = 1'b1; resync = 1'b1;
    @(posedge clk); #1;
    bit_sample = 1'b0; resync = 1'b0;
    tests++;
    if (sync_state !== 2'd0 || lock !== 1'b0 || frame_count !== 16'd1) begin
      fails++; $display("FAIL rs_state: got st=%0d lock=%b fc=%0d, want 0 0 1", sync_state, lock, frame_count);
    end
    tests++;
    if (word_valid !== 1'b0 || wq.size() != 62) begin
      fails++; $display("FAIL rs_words: got v=%b words=%0d, want v=0 words=62", word_valid, wq.size());
    end
    wq.delete();
    send_range(505, 1024);
    @(negedge clk);
    tests++;
    if (wq.size() != 0 || sync_state !== 2'd1) begin
      fails++; $display("FAIL rs_reacq: got words=%0d st=%0d, want 0 and 1", wq.size(), sync_state);
    end
    build_frame(4, '0); send_range(1, 1024);
    tests++;
    if (sync_state !== 2'd2 || frame_count !== 16'd1) begin
      fails++; $display("FAIL rs_relock: got st=%0d fc=%0d, want 2 and 1", sync_state, frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    wq.delete();
    build_frame(5, '0); send_range(1, 799);
    @(negedge clk);
    tests++;
    if (wq.size() != 99) begin
      fails++; $display("FAIL rm_words: got %0d, want 99", wq.size());
    end
    bit_in = st[800]; bit_sample = 1'b1; reset_n = 1'b0;
    @(posedge clk); #1;
    bit_sample = 1'b0;
    tests++;
    if ({word_valid, frame_start, word_data, word_index} !== 17'd0) begin
      fails++; $display("FAIL rm_word: got v=%b fs=%b d=%h i=%0d, want all 0", word_valid, frame_start, word_data, word_index);
    end
    tests++;
    if ({lock, sync_state, frame_count} !== 19'd0) begin
      fails++; $display("FAIL rm_status: got lock=%b st=%0d fc=%0d, want 0", lock, sync_state, frame_count);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_false_pattern();
    do_reset();
    for (int w = 0; w < 256; w++) st[8*w+1 +: 8] = pay_byte(w, 7);
    st[400 +: 26] = PAT;
    send_range(1, 425);
    tests++;
    if (sync_state !== 2'd1) begin
      fails++; $display("FAIL fp_verify: got %0d, want 1", sync_state);
    end
    send_range(426, 1448);
    tests++;
    if (sync_state !== 2'd1) begin
      fails++; $display("FAIL fp_hold: got %0d, want 1", sync_state);
    end
    send_range(1449, 1449);
    tests++;
    if (sync_state !== 2'd0) begin
      fails++; $display("FAIL fp_search: got %0d, want 0", sync_state);
    end
    send_range(1450, 2000);
    @(negedge clk);
    tests++;
    if (wq.size() != 0 || sync_state !== 2'd0) begin
      fails++; $display("FAIL fp_quiet: got words=%0d st=%0d, want 0 and 0", wq.size(), sync_state);
    end
  endtask

  task automatic test_max_errs();
    logic [25:0] mask [5] = '{26'h0, 26'h0, 26'h0000100, 26'h0000101, 26'h0};
    logic [1:0]  want0 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [1:0]  want1 [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd2};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      build_frame(f, mask[f]);
      send_range(1, 1024);
      tests++;
      if (sync_state !== want0[f] || e1_sync_state !== want1[f]) begin
        fails++; $display("FAIL me_state%0d: got e0=%0d e1=%0d, want e0=%0d e1=%0d", f, sync_state, e1_sync_state, want0[f], want1[f]);
      end
    end
    tests++;
    if (e1_lock !== 1'b1) begin
      fails++; $display("FAIL me_lock: got %b, want 1", e1_lock);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_flywheel();
    test_loss();
    test_resync();
    test_reset_mid_frame();
    test_false_pattern();
    test_max_errs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
